// File: rtl/bias_demap_pam_if.sv
// Frame handshake bundle for bias_demap_pam.
// The master drives a frame strobe and the packed frame; the slave returns
// the demapped symbols together with ready/busy/clip status.
interface bias_demap_pam_if #(
    parameter int M    = 8,
    parameter int N    = 16,
    parameter int logN = 4,
    parameter int BPS  = 2
);
    localparam int W = M + logN;

    logic                   valid;
    logic [N*W-1:0]         u;
    logic                   ready;
    logic                   busy;
    logic                   clip;
    logic [(N-1)*BPS-1:0]   y;

    modport master (output valid, output u, input ready, input busy, input clip, input y);
    modport slave  (input valid, input u, output ready, output busy, output clip, output y);
endinterface

// File: rtl/bias_demap_pam.sv
// DC-bias removal and M-PAM demapper for the DCO-OFDM receive path.
// A captured frame is summed one sample per cycle to get the truncating mean
// (the bias), then samples 1..N-1 are bias-corrected and sliced to PAM
// indices one per cycle. Sample 0 feeds the mean but is never demapped.
// Build option: define BIAS_DEMAP_GRAY_EN to emit Gray-coded slot codes
// instead of binary level indices.
//
// state | meaning
// IDLE  | waiting for the first frame strobe
// ACC   | accumulating samples 0..N-1 into the bias sum
// DEMAP | slicing samples 1..N-1 against the registered bias
// DONE  | result held on y/clip with ready high; accepts the next frame
module bias_demap_pam #(
    parameter int M        = 8,
    parameter int N        = 16,
    parameter int logN     = 4,
    parameter int BPS      = 2,
    parameter int LOG_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bias_demap_pam_if.slave  bus
);
    localparam int W  = M + logN;
    localparam int L  = 1 << BPS;
    localparam int SW = W + logN;
    localparam int TW = W + 2;
    localparam logic signed [TW-1:0] OFFS = TW'(L << LOG_STEP);
    localparam logic signed [TW-1:0] KMAX = TW'(L - 1);
    localparam logic [logN-1:0]      LAST = logN'(N - 1);

    typedef enum logic [1:0] {IDLE, ACC, DEMAP, DONE} state_t;

    state_t                 state;
    logic [W-1:0]           smp [N];
    logic [SW-1:0]          sum;
    logic [W-1:0]           bias;
    logic [logN-1:0]        idx;
    logic                   ready_q;
    logic                   busy_q;
    logic                   clip_q;
    logic [(N-1)*BPS-1:0]   y_q;

    logic [W-1:0]           cur;
    logic [SW-1:0]          sum_nxt;
    logic signed [W:0]      d;
    logic signed [TW-1:0]   t;
    logic signed [TW-1:0]   k;
    logic [BPS-1:0]         kc;
    logic [BPS-1:0]         code;
    logic                   clamp;

    // Datapath for the sample at idx: running sum for ACC, slicer for DEMAP.
    // Offsetting by L<<LOG_STEP turns the symmetric level grid into one that
    // starts at zero, so a plain arithmetic shift yields the level index.
    always_comb begin
        cur     = smp[idx];
        sum_nxt = sum + SW'(cur);
        d       = $signed({1'b0, cur}) - $signed({1'b0, bias});
        t       = TW'(d) + OFFS;
        k       = t >>> (LOG_STEP + 1);
        kc      = BPS'(k);
        clamp   = 1'b0;
        if (k[TW-1]) begin
            kc    = '0;
            clamp = 1'b1;
        end else if (k > KMAX) begin
            kc    = BPS'(L - 1);
            clamp = 1'b1;
        end
`ifdef BIAS_DEMAP_GRAY_EN
        code = kc ^ (kc >> 1);
`else
        code = kc;
`endif
    end

    // Sequencer: frame capture, accumulate, demap, and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            for (int i = 0; i < N; i++) smp[i] <= '0;
            sum     <= '0;
            bias    <= '0;
            idx     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            clip_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.valid) begin
                        for (int i = 0; i < N; i++) smp[i] <= bus.u[i*W +: W];
                        sum     <= '0;
                        idx     <= '0;
                        clip_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    sum <= sum_nxt;
                    if (idx == LAST) begin
                        bias  <= W'(sum_nxt >> logN);
                        idx   <= logN'(1);
                        state <= DEMAP;
                    end else begin
                        idx <= idx + logN'(1);
                    end
                end
                DEMAP: begin
                    y_q[(int'(idx) - 1)*BPS +: BPS] <= code;
                    if (clamp) clip_q <= 1'b1;
                    if (idx == LAST) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        idx <= idx + logN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.clip  = clip_q;
    assign bus.y     = y_q;
endmodule

// File: tb/tb_bias_demap_pam.sv
// Self-checking bench for bias_demap_pam with default parameters.
// Expected symbols come from an integer model of the mean/slice rules.
module tb_bias_demap_pam;
    localparam int M    = 8;
    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int BPS  = 2;
    localparam int LS   = 4;
    localparam int W    = M + LOGN;
    localparam int L    = 1 << BPS;
    localparam int YW   = (N - 1) * BPS;
    localparam int LAT  = 2 * N - 1;
    localparam int NB2B = 100;

    typedef int frame_t [N];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    bias_demap_pam_if #(.M(M), .N(N), .logN(LOGN), .BPS(BPS)) bus ();

    bias_demap_pam #(.M(M), .N(N), .logN(LOGN), .BPS(BPS), .LOG_STEP(LS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack(input frame_t s);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(s[i]);
        return r;
    endfunction

    // Mean of the frame, then each sample's nearest-level index by floor division.
    function automatic void model(input frame_t s, output logic [YW-1:0] ey, output logic ec);
        int sum, bias, d, t, k, step2, code;
        sum = 0;
        for (int i = 0; i < N; i++) sum += s[i];
        bias  = sum / N;
        step2 = 2 * (1 << LS);
        ey = '0;
        ec = 1'b0;
        for (int j = 1; j < N; j++) begin
            d = s[j] - bias;
            t = d + L * (1 << LS);
            if (t >= 0) k = t / step2;
            else        k = -((-t + step2 - 1) / step2);
            if (k < 0)     begin k = 0;     ec = 1'b1; end
            if (k > L - 1) begin k = L - 1; ec = 1'b1; end
`ifdef BIAS_DEMAP_GRAY_EN
            code = k ^ (k >> 1);
`else
            code = k;
`endif
            ey[(j-1)*BPS +: BPS] = BPS'(code);
        end
    endfunction

    function automatic frame_t rand_frame();
        frame_t s;
        int base, spread, v;
        base   = int'($urandom_range(3000, 300));
        spread = (($urandom_range(2, 0) == 0) ? 20 : (($urandom_range(1, 0) == 0) ? 60 : 150));
        for (int i = 0; i < N; i++) begin
            v = base + int'($urandom_range(2 * spread, 0)) - spread;
            if (v < 0) v = 0;
            if (v > (1 << W) - 1) v = (1 << W) - 1;
            s[i] = v;
        end
        return s;
    endfunction

    // Present a frame for one edge and count edges until ready rises.
    task automatic run_frame(input frame_t s, output int cycles);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.u     = pack(s);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        cycles = 0;
        while (!bus.ready && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid = 1'b0;
        bus.u = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        n_tests++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.clip !== 1'b0)  begin n_fail++; $display("FAIL reset_clip: got %b want 0", bus.clip); end
        n_tests++; if (bus.y !== '0)       begin n_fail++; $display("FAIL reset_y: got %h want 0", bus.y); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_flat();
        frame_t s; int cyc; logic [YW-1:0] ey; logic ec;
        for (int i = 0; i < N; i++) s[i] = 1000;
        model(s, ey, ec);
        run_frame(s, cyc);
        n_tests++; if (cyc !== LAT)    begin n_fail++; $display("FAIL flat_latency: got %0d want %0d", cyc, LAT); end
        n_tests++; if (bus.y !== ey)   begin n_fail++; $display("FAIL flat_y: got %h want %h", bus.y, ey); end
        n_tests++; if (bus.clip !== ec) begin n_fail++; $display("FAIL flat_clip: got %b want %b", bus.clip, ec); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flat_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_dc_offset();
        frame_t s; int cyc; logic [YW-1:0] ey; logic ec;
        for (int i = 0; i < N; i++) s[i] = 1000;
        s[0] = 1200;
        model(s, ey, ec);
        run_frame(s, cyc);
        n_tests++; if (cyc !== LAT)     begin n_fail++; $display("FAIL dc_latency: got %0d want %0d", cyc, LAT); end
        n_tests++; if (bus.y !== ey)    begin n_fail++; $display("FAIL dc_y: got %h want %h", bus.y, ey); end
        n_tests++; if (bus.clip !== ec) begin n_fail++; $display("FAIL dc_clip: got %b want %b", bus.clip, ec); end
    endtask

    task automatic test_clip();
        frame_t s; int cyc; logic [YW-1:0] ey; logic ec;
        for (int i = 0; i < N; i++) s[i] = 1000;
        s[5] = 1200;
        model(s, ey, ec);
        run_frame(s, cyc);
        n_tests++; if (cyc !== LAT)     begin n_fail++; $display("FAIL clip_latency: got %0d want %0d", cyc, LAT); end
        n_tests++; if (bus.y !== ey)    begin n_fail++; $display("FAIL clip_y: got %h want %h", bus.y, ey); end
        n_tests++; if (bus.clip !== 1'b1) begin n_fail++; $display("FAIL clip_flag: got %b want 1", bus.clip); end
    endtask

    task automatic test_reset_mid();
        frame_t s; int cyc; logic [YW-1:0] ey; logic ec;
        for (int i = 0; i < N; i++) s[i] = 1000;
        s[0] = 1200;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.u     = pack(s);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", bus.ready); end
        n_tests++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.clip !== 1'b0)  begin n_fail++; $display("FAIL rstmid_clip: got %b want 0", bus.clip); end
        n_tests++; if (bus.y !== '0)       begin n_fail++; $display("FAIL rstmid_y: got %h want 0", bus.y); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) s[i] = 1000;
        model(s, ey, ec);
        run_frame(s, cyc);
        n_tests++; if (cyc !== LAT)   begin n_fail++; $display("FAIL rstmid_latency: got %0d want %0d", cyc, LAT); end
        n_tests++; if (bus.y !== ey)  begin n_fail++; $display("FAIL rstmid_y_after: got %h want %h", bus.y, ey); end
    endtask

    task automatic test_busy_strobe();
        frame_t a, b; int cyc; logic [YW-1:0] ey, ey_b; logic ec, ec_b;
        a = rand_frame();
        do b = rand_frame(); while (pack(b) == pack(a));
        model(a, ey, ec);
        model(b, ey_b, ec_b);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.u     = pack(a);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        cyc = 0;
        while (!bus.ready && cyc < 100) begin
            if (cyc == 9) begin
                bus.valid = 1'b1;
                bus.u     = pack(b);
            end
            @(posedge clk);
            #1;
            bus.valid = 1'b0;
            cyc++;
        end
        n_tests++; if (cyc !== LAT)     begin n_fail++; $display("FAIL strobe_latency: got %0d want %0d", cyc, LAT); end
        n_tests++; if (bus.y !== ey)    begin n_fail++; $display("FAIL strobe_y: got %h want %h", bus.y, ey); end
        n_tests++; if (bus.clip !== ec) begin n_fail++; $display("FAIL strobe_clip: got %b want %b", bus.clip, ec); end
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL strobe_idle: got ready=%b busy=%b want ready=1 busy=0", bus.ready, bus.busy); end
        n_tests++; if (bus.y !== ey)    begin n_fail++; $display("FAIL strobe_hold: got %h want %h", bus.y, ey); end
    endtask

    task automatic test_back_to_back();
        frame_t frames [NB2B];
        int cyc; logic [YW-1:0] ey; logic ec;
        for (int f = 0; f < NB2B; f++) frames[f] = rand_frame();
        @(negedge clk);
        bus.valid = 1'b1;
        bus.u     = pack(frames[0]);
        @(posedge clk);
        #1;
        bus.u = pack(frames[1]);
        for (int f = 0; f < NB2B; f++) begin
            model(frames[f], ey, ec);
            cyc = 0;
            while (!bus.ready && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            n_tests++; if (cyc !== LAT)     begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", f, cyc, LAT); end
            n_tests++; if (bus.y !== ey)    begin n_fail++; $display("FAIL b2b_y[%0d]: got %h want %h", f, bus.y, ey); end
            n_tests++; if (bus.clip !== ec) begin n_fail++; $display("FAIL b2b_clip[%0d]: got %b want %b", f, bus.clip, ec); end
            if (f < NB2B - 1) begin
                @(posedge clk);
                #1;
                n_tests++; if (bus.ready !== 1'b0 || bus.busy !== 1'b1)
                    begin n_fail++; $display("FAIL b2b_restart[%0d]: got ready=%b busy=%b want ready=0 busy=1", f, bus.ready, bus.busy); end
                if (f + 2 < NB2B) bus.u = pack(frames[f+2]);
                else              bus.valid = 1'b0;
            end
        end
        bus.valid = 1'b0;
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.u     = '0;
        test_reset();
        test_flat();
        test_dc_offset();
        test_clip();
        test_reset_mid();
        test_busy_strobe();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bias_demap_pam.md
# bias_demap_pam

Parametrised DC-bias removal and M-PAM demapper for the Li-Fi DCO-OFDM receive path. It sits after the FFT/multiply stage. It accepts one frame of N unsigned biased samples and estimates the DC bias as the frame mean. It then subtracts the bias and slices samples 1..N-1 to `2**BPS`-level PAM indices. Unlike the previous fixed-M/4 demapper, it generalises the constellation order and decision spacing, processes one sample per cycle through a small FSM, and reports clipping.

## Interface
- `M`, 8, sample fractional/magnitude bits; sample width `W = M+logN`
- `N`, 16, samples per frame (power of two)
- `logN`, 4, log2(N)
- `BPS`, 2, bits per PAM symbol, 1..4; `L = 2**BPS` levels
- `LOG_STEP`, 4, decision half-spacing exponent; levels at `(2k-L+1)*2**LOG_STEP`, k=0..L-1

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `valid`  in  1  frame-start strobe; sampled only in IDLE or DONE
- `u`  in  `N*W`  frame; sample i = `u[i*W +: W]`, unsigned
- `ready`  out  1  result valid, level; held until next frame accepted
- `busy`  out  1  high in ACC and DEMAP
- `clip`  out  1  at least one demapped sample was clamped; valid with `ready`
- `y`  out  `(N-1)*BPS`  symbols; sample j (1..N-1) at `y[(j-1)*BPS +: BPS]`

## Operation
- States: IDLE, ACC, DEMAP, DONE. Reset: IDLE, `ready=0`, `busy=0`, `clip=0`, `y=0`, internal accumulator/index/bias = 0.
- IDLE or DONE with `valid=1` at an edge: capture `u` into the frame register, clear the sum, set `idx=0`, clear `clip`, clear `ready`, go to ACC. `y` keeps its old value until it is overwritten.
- ACC: each cycle, `sum += sample[idx]`. `sum` is `W+logN` bits and cannot overflow. At `idx=N-1`, register `bias = (sum + sample[N-1]) >> logN` (truncating mean, W bits), set `idx=1`, and go to DEMAP.
- DEMAP: each cycle, for `j=idx`:
  - `d = sample[j] - bias`, signed, W+1 bits.
  - `t = d + (L << LOG_STEP)`, signed, W+2 bits.
  - `k = t >>> (LOG_STEP+1)`, arithmetic shift.
  - If `k<0`, set `k=0` and `clip=1`. If `k>L-1`, set `k=L-1` and `clip=1`.
  - Write the code for `k` into slot j.
  - At `idx=N-1`, go to DONE and set `ready=1`.
- Sample 0 (the DC/Hermitian slot) contributes to the bias but is never demapped.
- `valid` during ACC/DEMAP is ignored; the frame in flight is not disturbed.
- `valid` in the same cycle that DONE is entered is not sampled. It is sampled from the next cycle.
- Asynchronous reset at any point aborts the frame and returns all outputs to their reset values immediately.

## Timing
- Acceptance edge A. ACC occupies edges A+1..A+N. DEMAP occupies A+N+1..A+2N-1. `ready` is high after edge A+2N-1, which is 31 cycles for N=16.
- `busy` rises after A and falls together with the rise of `ready`.
- Back-to-back operation: `valid` held high in DONE starts the next frame at the following edge, and `ready` drops at that same edge. The throughput is one frame per 2N cycles.
- `y` and `clip` are stable for as long as `ready=1`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BIAS_DEMAP_GRAY_EN` defined: slot code = Gray(k) = `k ^ (k>>1)`, matching the Gray-labelled PAM mapper.
- Not defined: slot code = binary k.
- Timing, clip and handshake behaviour are identical in both builds.

## Test plan
Default parameters (W=12, L=4, levels −48/−16/16/48).
- Reset: assert `rst_n=0` mid-DEMAP → immediately `ready=0`, `busy=0`, `y=0`, `clip=0`. After release, the next `valid` behaves normally.
- Flat frame: all samples 1000 → bias 1000, d=0, k=2. Each slot is `2'b10`, or `2'b11` with GRAY_EN. `clip=0`. `ready` rises exactly 31 cycles after the acceptance edge.
- DC-only offset: sample0=1200, others 1000 → bias 1012, d=−12, k=1. Each slot is `2'b01` in both builds. `clip=0`.
- Clip: sample0=1000, sample5=1200, others 1000 → bias 1012. Sample5 has d=188, computed k=7, clamped to 3, so slot 5 is `2'b11` (GRAY_EN: `2'b10`) and `clip=1`. Other slots have k=1.
- Busy-time strobe: pulse `valid` again at A+10 with a different `u` → the first result is unchanged, and the second frame is not started.
- Back-to-back: hold `valid=1` through DONE with 100 random frames → each `y` equals the golden model, and one frame completes every 32 cycles.
